// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, sending 3-byte frames followed by an idle gap
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [8*NUM_REQ-1:0]    cmd_in,
    input  logic [16*NUM_REQ-1:0]   data_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy,
    output logic                    trmt,
    output logic [7:0]              tx_data,
    input  logic                    tx_done
);
    typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_HI, SEND_LO, GAP} state_t;
    state_t state, state_n;
    logic [1:0] last, last_n, win, win_n, pick, idx;
    logic found;
    logic [7:0] f_cmd, f_cmd_n, f_hi, f_hi_n, f_lo, f_lo_n, gap_cnt, gap_cnt_n, tx_data_n;
    logic [NUM_REQ-1:0] gnt_n, done_n;
    logic trmt_n;
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NUM_REQ);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n   = state;
        last_n    = last;
        win_n     = win;
        f_cmd_n   = f_cmd;
        f_hi_n    = f_hi;
        f_lo_n    = f_lo;
        gap_cnt_n = gap_cnt;
        gnt_n     = '0;
        done_n    = '0;
        trmt_n    = 1'b0;
        tx_data_n = tx_data;
        case (state)
            IDLE: if (found) begin
                state_n   = SEND_CMD;
                last_n    = pick;
                win_n     = pick;
                f_cmd_n   = cmd_in[8*pick +: 8];
                f_hi_n    = data_in[16*pick+8 +: 8];
                f_lo_n    = data_in[16*pick +: 8];
                gnt_n     = NUM_REQ'(1) << pick;
                trmt_n    = 1'b1;
                tx_data_n = cmd_in[8*pick +: 8];
            end
            SEND_CMD: if (tx_done) begin
                state_n   = SEND_HI;
                trmt_n    = 1'b1;
                tx_data_n = f_hi;
            end
            SEND_HI: if (tx_done) begin
                state_n   = SEND_LO;
                trmt_n    = 1'b1;
                tx_data_n = f_lo;
            end
            SEND_LO: if (tx_done) begin
                done_n    = NUM_REQ'(1) << win;
                state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
                gap_cnt_n = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
            end
            GAP: begin
                state_n   = (gap_cnt == 8'd0) ? IDLE : GAP;
                gap_cnt_n = (gap_cnt == 8'd0) ? 8'd0 : gap_cnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 2'(NUM_REQ - 1);
            win     <= '0;
            f_cmd   <= '0;
            f_hi    <= '0;
            f_lo    <= '0;
            gap_cnt <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            trmt    <= 1'b0;
            tx_data <= '0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            win     <= win_n;
            f_cmd   <= f_cmd_n;
            f_hi    <= f_hi_n;
            f_lo    <= f_lo_n;
            gap_cnt <= gap_cnt_n;
            gnt     <= gnt_n;
            done    <= done_n;
            busy    <= (state_n != IDLE);
            trmt    <= trmt_n;
            tx_data <= tx_data_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests of arbitration, framing, gap timing and reset behaviour
module tb_uart_tx_arbiter;
    logic clk = 0, rst = 1;
    logic [1:0] req = 0, req0 = 0;
    logic [15:0] cmd_in = 0;
    logic [31:0] data_in = 0;
    logic [1:0] gnt, done, gnt0, done0;
    logic busy, trmt, busy0, trmt0;
    logic [7:0] tx_data, tx_data0;
    logic auto_done = 0, man_done = 0, tx_done0 = 0;
    logic tx_done;
    logic [3:0] ucnt = 0;
    int total = 0, bad = 0, cyc = 0, busy_last = 0;
    logic [7:0] bytes[$];
    int gnts[$], gnt_cyc[$], done_cyc[$], txd_cyc[$];
    logic [1:0] dones[$];
    logic prev_trmt = 0, trmt_twice = 0, overlap = 0;

    assign tx_done = auto_done | man_done;
    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in), .data_in(data_in),
        .gnt(gnt), .done(done), .busy(busy), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done));

    uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .cmd_in(cmd_in), .data_in(data_in),
        .gnt(gnt0), .done(done0), .busy(busy0), .trmt(trmt0), .tx_data(tx_data0), .tx_done(tx_done0));

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: byte completes 10 cycles after its start pulse
    always @(posedge clk) begin
        if (rst) begin
            ucnt <= 0;
            auto_done <= 0;
        end else begin
            auto_done <= 0;
            if (trmt) ucnt <= 4'd10;
            else if (ucnt != 0) begin
                ucnt <= ucnt - 1;
                if (ucnt == 1) auto_done <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (trmt) bytes.push_back(tx_data);
        if (gnt != 0) begin gnts.push_back(gnt[1] ? 1 : 0); gnt_cyc.push_back(cyc); end
        if (done != 0) begin dones.push_back(done); done_cyc.push_back(cyc); end
        if (tx_done) txd_cyc.push_back(cyc);
        if (busy) busy_last = cyc;
        if (trmt && prev_trmt) trmt_twice = 1;
        if (gnt != 0 && done != 0) overlap = 1;
        prev_trmt = trmt;
    end

    task automatic clear_logs();
        bytes.delete(); gnts.delete(); gnt_cyc.delete(); done_cyc.delete();
        txd_cyc.delete(); dones.delete(); trmt_twice = 0; overlap = 0;
    endtask

    task automatic wait_gnt(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (gnt != 0) begin ok = 1; break; end
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1; req = 2'b11; cmd_in = 16'h2211; data_in = 32'h4444_3333;
        repeat (3) @(negedge clk);
        total++; if ({gnt, done, busy, trmt} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {gnt, done, busy, trmt}); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_txdata got=%h exp=00", tx_data); end
        rst = 0;
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL release_gnt got=%b exp=01", gnt); end
        total++; if (tx_data !== 8'h11) begin bad++; $display("FAIL release_txdata got=%h exp=11", tx_data); end
        total++; if ({trmt, busy} !== 2'b11) begin bad++; $display("FAIL release_trmt_busy got=%b exp=11", {trmt, busy}); end
        req = 0;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_frame_timeout got=busy exp=idle"); end
    endtask

    task automatic test_single();
        bit ok;
        logic [7:0] exp_b[3] = '{8'hA5, 8'h12, 8'h34};
        int d;
        clear_logs();
        @(negedge clk);
        req = 2'b10; cmd_in = 16'hA500; data_in = 32'h1234_0000;
        wait_gnt(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_gnt_timeout got=none exp=gnt"); end
        req = 0;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_idle_timeout got=busy exp=idle"); end
        total++; if (bytes.size() != 3) begin bad++; $display("FAIL single_trmt_count got=%0d exp=3", bytes.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (bytes.size() > i && bytes[i] !== exp_b[i]) begin bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, bytes[i], exp_b[i]); end
        end
        total++; if (dones.size() != 1 || dones[0] !== 2'b10) begin bad++; $display("FAIL single_done got=%0d pulses exp=1 pulse of 10", dones.size()); end
        total++; if (gnts.size() != 1 || gnts[0] != 1) begin bad++; $display("FAIL single_gnt_idx got=%0d grants exp=1 grant to 1", gnts.size()); end
        d = (done_cyc.size() > 0 && txd_cyc.size() > 0) ? done_cyc[0] - txd_cyc[txd_cyc.size()-1] : -999;
        total++; if (d != 1) begin bad++; $display("FAIL single_done_latency got=%0d exp=1", d); end
        d = (done_cyc.size() > 0) ? busy_last - done_cyc[0] : -999;
        total++; if (d != 3) begin bad++; $display("FAIL single_gap_busy got=%0d exp=3", d); end
        total++; if ({trmt_twice, overlap} !== 2'b00) begin bad++; $display("FAIL single_invariants got=%b exp=00", {trmt_twice, overlap}); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int n = 0, d;
        int exp_g[4] = '{0, 1, 0, 1};
        logic [7:0] exp_b[12] = '{8'hA0, 8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3,
                                  8'hA0, 8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3};
        clear_logs();
        @(negedge clk);
        req = 2'b11; cmd_in = 16'hB1A0; data_in = 32'hB2B3_A1A2;
        for (int i = 0; i < 600 && n < 4; i++) begin
            @(negedge clk);
            if (gnt != 0) n++;
        end
        req = 0;
        total++; if (n != 4) begin bad++; $display("FAIL rr_grants got=%0d exp=4", n); end
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_idle_timeout got=busy exp=idle"); end
        for (int i = 0; i < 4; i++) begin
            total++; if (gnts.size() <= i || gnts[i] != exp_g[i]) begin bad++; $display("FAIL rr_order%0d got=%0d exp=%0d", i, gnts.size() > i ? gnts[i] : -1, exp_g[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            d = (gnt_cyc.size() > i && done_cyc.size() >= i) ? gnt_cyc[i] - done_cyc[i-1] : -999;
            total++; if (d != 5) begin bad++; $display("FAIL rr_spacing%0d got=%0d exp=5", i, d); end
        end
        total++; if (bytes.size() != 12) begin bad++; $display("FAIL rr_byte_count got=%0d exp=12", bytes.size()); end
        for (int i = 0; i < 12; i++) begin
            total++; if (bytes.size() > i && bytes[i] !== exp_b[i]) begin bad++; $display("FAIL rr_byte%0d got=%h exp=%h", i, bytes[i], exp_b[i]); end
        end
        total++; if ({trmt_twice, overlap} !== 2'b00) begin bad++; $display("FAIL rr_invariants got=%b exp=00", {trmt_twice, overlap}); end
    endtask

    task automatic test_isolation();
        bit ok;
        logic [7:0] exp_b[3] = '{8'h5A, 8'hC3, 8'hD4};
        clear_logs();
        @(negedge clk);
        req = 2'b01; cmd_in = 16'h005A; data_in = 32'h0000_C3D4;
        wait_gnt(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL iso_gnt_timeout got=none exp=gnt"); end
        req = 0;
        @(negedge clk);
        cmd_in[7:0] = 8'hFF; data_in[15:0] = 16'hFFFF;
        wait_idle(200, ok);
        total++; if (bytes.size() != 3) begin bad++; $display("FAIL iso_count got=%0d exp=3", bytes.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (bytes.size() > i && bytes[i] !== exp_b[i]) begin bad++; $display("FAIL iso_byte%0d got=%h exp=%h", i, bytes[i], exp_b[i]); end
        end
    endtask

    task automatic test_spurious();
        bit ok;
        int d;
        clear_logs();
        @(negedge clk);
        man_done = 1;
        @(negedge clk);
        man_done = 0;
        total++; if ({trmt, busy} !== 2'b00) begin bad++; $display("FAIL spur_idle got=%b exp=00", {trmt, busy}); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || bytes.size() != 0) begin bad++; $display("FAIL spur_idle_after got=%b/%0d exp=0/0", busy, bytes.size()); end
        req = 2'b01; cmd_in = 16'h0033; data_in = 32'h0000_4455;
        wait_gnt(20, ok);
        req = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done != 0) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL spur_done_timeout got=none exp=done"); end
        man_done = 1;
        @(negedge clk);
        man_done = 0;
        total++; if ({trmt, busy} !== 2'b01) begin bad++; $display("FAIL spur_gap got=%b exp=01", {trmt, busy}); end
        wait_idle(50, ok);
        total++; if (bytes.size() != 3) begin bad++; $display("FAIL spur_trmt_count got=%0d exp=3", bytes.size()); end
        d = (done_cyc.size() > 0) ? busy_last - done_cyc[0] : -999;
        total++; if (d != 3) begin bad++; $display("FAIL spur_gap_len got=%0d exp=3", d); end
    endtask

    task automatic test_gap0();
        bit ok = 0;
        logic [7:0] exp_b[2] = '{8'h9A, 8'hBC};
        @(negedge clk);
        req0 = 2'b01; cmd_in = 16'h8877; data_in = 32'h0000_9ABC;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0 != 0) begin ok = 1; break; end
        end
        req0 = 0;
        total++; if (!ok || tx_data0 !== 8'h77) begin bad++; $display("FAIL g0_gnt got=%h exp=77", tx_data0); end
        for (int b = 0; b < 3; b++) begin
            repeat (3) @(negedge clk);
            if (b == 2) req0 = 2'b10;
            tx_done0 = 1;
            @(negedge clk);
            tx_done0 = 0;
            if (b < 2) begin
                total++; if (trmt0 !== 1'b1 || tx_data0 !== exp_b[b]) begin bad++; $display("FAIL g0_byte%0d got=%b/%h exp=1/%h", b, trmt0, tx_data0, exp_b[b]); end
            end else begin
                total++; if ({done0, busy0, trmt0} !== 4'b0100) begin bad++; $display("FAIL g0_done got=%b exp=0100", {done0, busy0, trmt0}); end
            end
        end
        @(negedge clk);
        total++; if (gnt0 !== 2'b10 || tx_data0 !== 8'h88) begin bad++; $display("FAIL g0_regrant got=%b/%h exp=10/88", gnt0, tx_data0); end
        req0 = 0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int n = 0;
        clear_logs();
        @(negedge clk);
        req = 2'b01; cmd_in = 16'h00C0; data_in = 32'h0000_C1C2;
        wait_gnt(20, ok);
        req = 0;
        if (ok) n = 1;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge clk);
            if (trmt) n++;
        end
        total++; if (n != 2 || tx_data !== 8'hC1) begin bad++; $display("FAIL mr_reach_hi got=%0d/%h exp=2/c1", n, tx_data); end
        rst = 1;
        @(negedge clk);
        total++; if ({gnt, done, busy, trmt} !== 6'b0) begin bad++; $display("FAIL mr_ctrl got=%b exp=000000", {gnt, done, busy, trmt}); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mr_txdata got=%h exp=00", tx_data); end
        rst = 0; req = 2'b11;
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mr_first_gnt got=%b exp=01", gnt); end
        total++; if (dones.size() != 0) begin bad++; $display("FAIL mr_no_done got=%0d exp=0", dones.size()); end
        req = 0;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL mr_idle_timeout got=busy exp=idle"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_isolation();
        test_spurious();
        test_gap0();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one 8-bit UART transmitter among up to four requesters, each sending 24-bit frames (8-bit command, then 16-bit data high byte, then low byte). The block sits between the command sources (host-side command generators, test-bench drivers) and the UART `trmt`/`tx_data`/`tx_done` handshake. Each granted frame goes out as one unbroken three-byte burst, followed by a programmable idle gap.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `GAP_CYCLES`, default 4: idle clocks inserted after each frame before the next grant; 0 is legal; counter width is 8 bits.

- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req` in NUM_REQ: per-requester frame request; level, held until the matching `gnt` bit pulses.
- `cmd_in` in 8*NUM_REQ: requester i command at bits [8i+7:8i].
- `data_in` in 16*NUM_REQ: requester i data at bits [16i+15:16i].
- `gnt` out NUM_REQ: one-hot, 1-cycle pulse; the frame was captured and the requester may change its inputs.
- `done` out NUM_REQ: one-hot, 1-cycle pulse; the last byte of that requester's frame has finished.
- `busy` out 1: high in every state except IDLE.
- `trmt` out 1: 1-cycle start pulse to the UART transmitter.
- `tx_data` out 8: byte presented to the UART; held stable between `trmt` pulses.
- `tx_done` in 1: UART byte-complete; treated as a pulse, with any high cycle counted once per byte.

## Operation
- States: IDLE, SEND_CMD, SEND_HI, SEND_LO, GAP.
- **Arbitration in IDLE:**
  - The block keeps a pointer `last`, the index of the last grantee.
  - The search order is `last+1`, `last+2`, … modulo NUM_REQ; the first requester with `req` set wins.
  - On reset, `last` = NUM_REQ-1, so requester 0 has top priority first.
  - `last` updates only on a grant.
- **Capture on grant:**
  - The winner's `cmd`, `data[15:8]` and `data[7:0]` are latched into internal frame registers, along with the winner index.
  - After capture the block ignores `req`, `cmd_in` and `data_in` until the state returns to IDLE.
- **Transitions:**
  - IDLE → SEND_CMD when any `req` is set. Registered outputs: `gnt[w]`=1, `trmt`=1, `tx_data`=cmd.
  - SEND_CMD → SEND_HI on `tx_done`. Registered outputs: `trmt`=1, `tx_data`=data[15:8].
  - SEND_HI → SEND_LO on `tx_done`. Registered outputs: `trmt`=1, `tx_data`=data[7:0].
  - SEND_LO on `tx_done`: `done[w]`=1. Next state is GAP with counter loaded to GAP_CYCLES-1, or IDLE directly when GAP_CYCLES=0.
  - GAP: the counter decrements each cycle; at 0 the next state is IDLE.
- `tx_done` seen in IDLE or GAP is ignored.
- `tx_data` holds its last value in IDLE and GAP.
- A requester that keeps `req` high after its `gnt` is treated as a new request. Rotation guarantees that any other pending requester is served before it.
- Reset mid-frame aborts the frame:
  - No `done` is issued.
  - `trmt` is low in the following cycle.
  - The UART may still be shifting a byte; this is accepted.

## Timing
- All outputs are registered.
- Reset values: `gnt`=0, `done`=0, `busy`=0, `trmt`=0, `tx_data`=8'h00, state IDLE, `last`=NUM_REQ-1, gap counter 0.
- Edge k samples `req` in IDLE. In the cycle after edge k, `gnt`, `trmt` and `busy` are high and `tx_data`=cmd.
- Each `tx_done` seen at edge m produces `trmt` high in cycle m+1, with the new `tx_data` valid in that same cycle.
- The final `tx_done` at edge m produces `done` high in cycle m+1.
- Next earliest grant:
  - With GAP_CYCLES=G≥1, `busy` stays high for cycles m+1 … m+G. IDLE is re-entered at edge m+G+1, and the earliest next `gnt` is cycle m+G+2.
  - With G=0, IDLE is re-entered at edge m+1 and the earliest next `gnt` is cycle m+2.
- `gnt` and `trmt` of the first byte are coincident.
- `done` never coincides with `gnt`.
- `trmt` is never high for two consecutive cycles.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `req`=2'b11 → all outputs 0. Release → the next cycle shows `gnt`=2'b01, `tx_data`=`cmd_in[7:0]`.
- **Single frame:** requester 1 sends cmd=8'hA5, data=16'h1234, and the UART model returns `tx_done` 10 cycles after each `trmt`.
  - Required: `tx_data` sequence A5, 12, 34, with exactly three `trmt` pulses.
  - `done`=2'b10 pulses one cycle after the third `tx_done`.
  - `busy` stays high for GAP_CYCLES=4 further cycles.
- **Round-robin:** `req`=2'b11 held continuously with NUM_REQ=2 → grant order 0,1,0,1 over four frames; the next grant is never earlier than 6 cycles after the previous final `tx_done`.
- **Input isolation:** change requester 0's `cmd_in`/`data_in` to 8'hFF/16'hFFFF one cycle after its `gnt` → the transmitted bytes still equal the values captured at the grant edge.
- **Spurious handshake:** pulse `tx_done` in IDLE and in GAP → no `trmt`, no state change. With GAP_CYCLES=0, a `req` held during `done` is granted one cycle after the `done` pulse.
- **Mid-frame reset:** assert `rst` during SEND_HI → no `done` pulse; all outputs read their reset values the cycle after the edge that samples `rst`. After release, requester 0 is granted first.
